// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero flagging and a start/cancel/ready handshake.
module div_iter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               signed_div_i,
    input  logic               start_i,
    input  logic               cancel_i,
    output logic [2*WIDTH-1:0] div_result_o,
    output logic               div_ready_o,
    output logic               div_by_zero_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        END
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   dvd_q;      // dividend magnitude, refilled with quotient bits
    logic [WIDTH-1:0]   dsr_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;

    logic               accept;
    logic               div_zero;
    logic               last_step;
    logic [WIDTH:0]     rem_sh;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept    = start_i & ~cancel_i;
    assign div_zero  = (opdata2_i == '0);
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        q_bit   = (rem_sh >= {1'b0, dsr_q});
        rem_nxt = q_bit ? WIDTH'(rem_sh - {1'b0, dsr_q}) : rem_sh[WIDTH-1:0];
        quo_nxt = {dvd_q[WIDTH-2:0], q_bit};
        quo_fix = neg_q_q ? -quo_nxt : quo_nxt;
        rem_fix = neg_r_q ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = div_zero ? END : ON;
                end
            end
            ON: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = END;
                end
            end
            END: begin
                if (!start_i || cancel_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            result_q <= {opdata1_i, {WIDTH{1'b1}}};
                            dbz_q    <= 1'b1;
                        end else begin
                            dvd_q   <= mag(opdata1_i, signed_div_i);
                            dsr_q   <= mag(opdata2_i, signed_div_i);
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            neg_q_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_r_q <= signed_div_i & opdata1_i[WIDTH-1];
                        end
                    end
                end
                ON: begin
                    // Cancel wins over completion: nothing is registered on a flush
                    if (!cancel_i) begin
                        rem_q <= rem_nxt;
                        dvd_q <= quo_nxt;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_step) begin
                            result_q <= {rem_fix, quo_fix};
                        end
                    end
                end
                END: begin
                    if (!start_i || cancel_i) begin
                        result_q <= '0;
                        dbz_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_result_o  = result_q;
    assign div_by_zero_o = dbz_q;
    assign div_ready_o   = (state_q == END);
    assign busy_o        = (state_q == ON);

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (WIDTH=32 and WIDTH=8 instances).
module tb_div_iter;

    logic        clk;
    logic        rst;

    logic [31:0] a32, b32;
    logic        s32, start32, cancel32;
    logic [63:0] res32;
    logic        rdy32, dbz32, busy32;

    logic [7:0]  a8, b8;
    logic        s8, start8, cancel8;
    logic [15:0] res8;
    logic        rdy8, dbz8, busy8;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int edges, busy_n;

    div_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .opdata1_i(a32), .opdata2_i(b32), .signed_div_i(s32),
        .start_i(start32), .cancel_i(cancel32),
        .div_result_o(res32), .div_ready_o(rdy32),
        .div_by_zero_o(dbz32), .busy_o(busy32)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .opdata1_i(a8), .opdata2_i(b8), .signed_div_i(s8),
        .start_i(start8), .cancel_i(cancel8),
        .div_result_o(res8), .div_ready_o(rdy8),
        .div_by_zero_o(dbz8), .busy_o(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // edges counts the accepting edge as edge 1
    task automatic wait32(output int e, output int b);
        e = 1;
        b = 0;
        while (!rdy32 && e < 60) begin
            if (busy32) b++;
            tick();
            e++;
        end
    endtask

    task automatic wait8(output int e);
        e = 1;
        while (!rdy8 && e < 30) begin
            tick();
            e++;
        end
    endtask

    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic s);
        a32 = a; b32 = b; s32 = s; start32 = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        a32 = '0; b32 = '0; s32 = 1'b0; start32 = 1'b0; cancel32 = 1'b0;
        a8 = '0; b8 = '0; s8 = 1'b0; start8 = 1'b0; cancel8 = 1'b0;
        #1;
        check("reset_res32", res32, 64'h0);
        check("reset_flags32", {61'h0, rdy32, dbz32, busy32}, 64'h0);
        tick();
        rst = 1'b1;
        tick();

        // unsigned 100/7 with start held
        go32(32'd100, 32'd7, 1'b0);
        check("u100_7_busy_at_accept", {63'h0, busy32}, 64'h1);
        wait32(edges, busy_n);
        check("u100_7_latency", 64'(edges), 64'd33);
        check("u100_7_busy_cycles", 64'(busy_n), 64'd32);
        check("u100_7_result", res32, {32'd2, 32'd14});
        check("u100_7_dbz", {63'h0, dbz32}, 64'h0);
        tick();
        check("u100_7_hold_ready", {62'h0, rdy32, busy32}, 64'h2);
        start32 = 1'b0;
        tick();
        check("u100_7_drop_ready", {63'h0, rdy32}, 64'h0);
        check("u100_7_drop_result", res32, 64'h0);

        // signed -7/2
        go32(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait32(edges, busy_n);
        check("s_m7_2_result", res32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        start32 = 1'b0; tick();

        // signed 7/-2
        go32(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait32(edges, busy_n);
        check("s_7_m2_result", res32, {32'd1, 32'hFFFF_FFFD});
        start32 = 1'b0; tick();

        // signed -8/-3
        go32(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1);
        wait32(edges, busy_n);
        check("s_m8_m3_result", res32, {32'hFFFF_FFFE, 32'd2});
        start32 = 1'b0; tick();

        // signed MIN / -1 wraps
        go32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait32(edges, busy_n);
        check("s_min_m1_result", res32, {32'h0, 32'h8000_0000});
        check("s_min_m1_dbz", {63'h0, dbz32}, 64'h0);
        start32 = 1'b0; tick();

        // unsigned large operands, no sign handling
        go32(32'hFFFF_FFFF, 32'h0001_0000, 1'b0);
        wait32(edges, busy_n);
        check("u_big_result", res32, {32'h0000_FFFF, 32'h0000_FFFF});
        start32 = 1'b0; tick();

        // divide by zero
        go32(32'h0000_1234, 32'h0, 1'b0);
        check("dz_ready_1edge", {62'h0, rdy32, busy32}, 64'h2);
        check("dz_result", res32, {32'h0000_1234, 32'hFFFF_FFFF});
        check("dz_flag", {63'h0, dbz32}, 64'h1);
        start32 = 1'b0; tick();
        check("dz_clear", {res32[62:0], dbz32}, 64'h0);

        // cancel at step 10, then restart
        go32(32'd100, 32'd7, 1'b0);
        start32 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("cancel_busy_before", {62'h0, rdy32, busy32}, 64'h1);
        cancel32 = 1'b1;
        tick();
        cancel32 = 1'b0;
        check("cancel_idle", {62'h0, rdy32, busy32}, 64'h0);
        check("cancel_result", res32, 64'h0);
        go32(32'd1000, 32'd10, 1'b0);
        check("restart_busy", {63'h0, busy32}, 64'h1);
        wait32(edges, busy_n);
        check("restart_latency", 64'(edges), 64'd33);
        check("restart_result", res32, {32'd0, 32'd100});
        start32 = 1'b0; tick();

        // WIDTH=8 unsigned 255/16
        a8 = 8'd255; b8 = 8'd16; s8 = 1'b0; start8 = 1'b1;
        tick();
        wait8(edges);
        check("w8_latency", 64'(edges), 64'd9);
        check("w8_result", 64'(res8), 64'h0F0F);
        start8 = 1'b0; tick();

        // WIDTH=8 signed -128/3 -> q=-42, r=-2
        a8 = 8'h80; b8 = 8'd3; s8 = 1'b1; start8 = 1'b1;
        tick();
        wait8(edges);
        check("w8_signed_result", 64'(res8), 64'hFED6);
        start8 = 1'b0; tick();

        // async reset mid-operation
        a8 = 8'd200; b8 = 8'd9; s8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        check("w8_busy_pre_rst", {63'h0, busy8}, 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("w8_async_rst", {46'h0, res8, rdy8, dbz8}, 64'h0);
        check("w8_async_rst_busy", {63'h0, busy8}, 64'h0);
        tick();
        rst = 1'b1;
        tick();
        check("w8_post_rst_idle", {61'h0, rdy8, dbz8, busy8}, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
